// File: rtl/flipflop_treset_pkg.sv
// Shared types and helpers for the staged soft-reset sequencer.
//
// Contents:
//   treset_state_e : sequencer states (IDLE, ARM, HOLD, RELEASE)
//   min_cnt_w()    : smallest counter width able to hold the largest
//                    delay/stagger/watchdog limit
package flipflop_treset_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } treset_state_e;

  function automatic int unsigned min_cnt_w(input int unsigned delay,
                                            input int unsigned stagger,
                                            input int unsigned timeout);
    int unsigned m;
    int unsigned w;
    m = delay;
    if (stagger > m) m = stagger;
    if (timeout > m) m = timeout;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((m >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/flipflop_treset_tick.sv
// Loadable, saturating up-counter with a terminal-match flag.
// Shared by the arm delay, the channel stagger spacing and the watchdog.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val (priority over inc)
//   load_val : value loaded on load
//   inc      : count up by one, holding at all-ones
//   limit    : terminal value
//   match    : count == limit
module flipflop_treset_tick #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic [CNT_W-1:0] limit,
  output logic             match
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign match = (count == limit);

endmodule

// File: rtl/flipflop_treset_seq.sv
// Staged soft-reset sequencer: turns a level soft-reset request into a
// latched multi-channel reset level. Assertion waits DELAY edges of a
// continuously high Req; release is acknowledged by Clear (with Req low)
// and then walks from channel 0 upward, STAGGER edges per channel.
//
// Optional watchdog: define FLIPFLOP_TRESET_WDOG_EN to force a release
// after HOLD_TIMEOUT quiet edges in HOLD and raise a sticky Timeout.
//
// Ports:
//   Clk     : clock, rising edge
//   RESET   : synchronous active-high hard reset (enters HOLD, all channels held)
//   Req     : soft reset request, level
//   Clear   : release acknowledge, honoured only while Req is low
//   TRESET  : per-channel reset level (1 = held in reset)
//   Busy    : high whenever the sequencer is not IDLE
//   Done    : one-cycle pulse after the last channel releases
//   Timeout : sticky watchdog flag (0 when the watchdog is compiled out)
module flipflop_treset_seq
  import flipflop_treset_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned DELAY        = 2,
  parameter int unsigned STAGGER      = 1,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned HOLD_TIMEOUT = 64
) (
  input  logic                Clk,
  input  logic                RESET,
  input  logic                Req,
  input  logic                Clear,
  output logic [CHANNELS-1:0] TRESET,
  output logic                Busy,
  output logic                Done,
  output logic                Timeout
);

  if (CHANNELS == 0 || CHANNELS > 16) begin : g_bad_channels
    $error("CHANNELS must be in 1..16");
  end
  if (DELAY == 0) begin : g_bad_delay
    $error("DELAY must be at least 1");
  end
  if (HOLD_TIMEOUT == 0) begin : g_bad_timeout
    $error("HOLD_TIMEOUT must be at least 1");
  end
  if (CNT_W < min_cnt_w(DELAY, STAGGER, HOLD_TIMEOUT)) begin : g_bad_cnt_w
    $error("CNT_W too small for DELAY/STAGGER/HOLD_TIMEOUT");
  end

  // Counters match on the edge that completes the interval, hence limit-1.
  localparam logic [CNT_W-1:0]    ARM_LIM     = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0]    STG_LIM     = CNT_W'((STAGGER == 0) ? 0 : STAGGER - 1);
  localparam logic [CNT_W-1:0]    WD_LIM      = CNT_W'(HOLD_TIMEOUT - 1);
  localparam bit                  ALL_AT_ONCE = (STAGGER == 0) || (CHANNELS == 1);
  localparam logic [4:0]          LAST_IDX    = 5'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] CH0         = CHANNELS'(1);

  treset_state_e       state;
  logic [CHANNELS-1:0] treset_q;
  logic                busy_q;
  logic                done_q;
  logic [4:0]          idx;       // next channel to release
  logic                arm_match;
  logic                stg_match;
  logic                wd_fire;

  flipflop_treset_tick #(.CNT_W(CNT_W)) u_arm_tick (
    .clk      (Clk),
    .rst      (RESET),
    .load     (state != ARM),
    .load_val ('0),
    .inc      (state == ARM),
    .limit    (ARM_LIM),
    .match    (arm_match)
  );

  // Restarted after every channel release so each gap is STAGGER edges.
  flipflop_treset_tick #(.CNT_W(CNT_W)) u_stg_tick (
    .clk      (Clk),
    .rst      (RESET),
    .load     ((state != RELEASE) || stg_match),
    .load_val ('0),
    .inc      (state == RELEASE),
    .limit    (STG_LIM),
    .match    (stg_match)
  );

`ifdef FLIPFLOP_TRESET_WDOG_EN
  logic wd_match;
  logic timeout_q;

  flipflop_treset_tick #(.CNT_W(CNT_W)) u_wd_tick (
    .clk      (Clk),
    .rst      (RESET),
    .load     ((state != HOLD) || Req),
    .load_val ('0),
    .inc      ((state == HOLD) && !Req && !Clear),
    .limit    (WD_LIM),
    .match    (wd_match)
  );

  assign wd_fire = wd_match && !Clear;

  always_ff @(posedge Clk) begin
    if (RESET) begin
      timeout_q <= 1'b0;
    end else if ((state == HOLD) && !Req && wd_fire) begin
      timeout_q <= 1'b1;
    end
  end

  assign Timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign Timeout = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state    <= HOLD;
      treset_q <= '1;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      idx      <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          treset_q <= '0;
          if (Req) begin
            state  <= ARM;
            busy_q <= 1'b1;
          end
        end
        ARM: begin
          if (!Req) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (arm_match) begin
            state    <= HOLD;
            treset_q <= '1;
          end
        end
        HOLD: begin
          treset_q <= '1;
          if (!Req && (Clear || wd_fire)) begin
            if (ALL_AT_ONCE) begin
              state    <= IDLE;
              treset_q <= '0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              state    <= RELEASE;
              treset_q <= ~CH0;
              idx      <= 5'd1;
            end
          end
        end
        RELEASE: begin
          if (Req) begin
            state    <= HOLD;
            treset_q <= '1;
          end else if (stg_match) begin
            treset_q <= treset_q & ~(CH0 << idx);
            idx      <= idx + 5'd1;
            if (idx == LAST_IDX) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign TRESET = treset_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_flipflop_treset_seq.sv
// Self-checking bench for flipflop_treset_seq (CHANNELS=4, DELAY=2,
// STAGGER=1, HOLD_TIMEOUT=8). Directed sequences followed by random
// Req/Clear/RESET traffic, compared each cycle against a timeline model.
module tb_flipflop_treset_seq;

  localparam int CH      = 4;
  localparam int DLY     = 2;
  localparam int STG     = 1;
  localparam int TMO     = 8;
`ifdef FLIPFLOP_TRESET_WDOG_EN
  localparam bit WDOG    = 1'b1;
`else
  localparam bit WDOG    = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          RESET = 1'b1;
  logic          Req = 1'b0;
  logic          Clear = 1'b0;
  logic [CH-1:0] TRESET;
  logic          Busy;
  logic          Done;
  logic          Timeout;

  flipflop_treset_seq #(
    .CHANNELS     (CH),
    .DELAY        (DLY),
    .STAGGER      (STG),
    .CNT_W        (8),
    .HOLD_TIMEOUT (TMO)
  ) dut (
    .Clk     (Clk),
    .RESET   (RESET),
    .Req     (Req),
    .Clear   (Clear),
    .TRESET  (TRESET),
    .Busy    (Busy),
    .Done    (Done),
    .Timeout (Timeout)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: arming counts consecutive high Req samples, release
  // derives the number of freed channels from edges elapsed since r0.
  int            run;      // high Req samples since leaving idle (0 = not arming)
  bit            holding;
  int            rel_k;    // edges since release start, -1 when not releasing
  int            quiet;    // consecutive quiet edges while holding
  bit            exp_done;
  bit            exp_to;
  logic [CH-1:0] exp_tr;

  task automatic apply_release();
    int n;
    logic [CH-1:0] ones;
    ones = '1;
    if (STG == 0) n = CH;
    else n = (rel_k / STG + 1 > CH) ? CH : rel_k / STG + 1;
    exp_tr = ones << n;
    if (n == CH) begin
      rel_k    = -1;
      exp_done = 1'b1;
    end
  endtask

  task automatic model_step(input bit r, input bit q, input bit c);
    exp_done = 1'b0;
    if (r) begin
      holding = 1'b1; rel_k = -1; run = 0; quiet = 0; exp_to = 1'b0;
      exp_tr = '1;
    end else if (holding) begin
      if (q) begin
        quiet = 0;
      end else if (c || (WDOG && quiet + 1 >= TMO)) begin
        if (!c) exp_to = 1'b1;
        holding = 1'b0; quiet = 0; rel_k = 0;
        apply_release();
      end else begin
        quiet++;
      end
    end else if (rel_k >= 0) begin
      if (q) begin
        holding = 1'b1; rel_k = -1; quiet = 0; exp_tr = '1;
      end else begin
        rel_k++;
        apply_release();
      end
    end else if (run > 0) begin
      if (!q) run = 0;
      else begin
        run++;
        if (run > DLY) begin
          holding = 1'b1; run = 0; quiet = 0; exp_tr = '1;
        end
      end
    end else if (q) begin
      run = 1;
    end
  endtask

  task automatic cyc(input bit r, input bit q, input bit c);
    RESET = r; Req = q; Clear = c;
    @(posedge Clk);
    model_step(r, q, c);
    #1;
    check("treset",  32'(TRESET),  32'(exp_tr));
    check("busy",    32'(Busy),    32'(holding || rel_k >= 0 || run > 0));
    check("done",    32'(Done),    32'(exp_done));
    check("timeout", 32'(Timeout), 32'(exp_to));
  endtask

  bit rq;

  initial begin
    run = 0; holding = 1'b0; rel_k = -1; quiet = 0;
    exp_done = 1'b0; exp_to = 1'b0; exp_tr = '0;

    // Hard reset, then acknowledged staggered release.
    cyc(1, 0, 0);
    check("rst_treset_const", 32'(TRESET), 32'hF);
    cyc(0, 0, 1);
    repeat (6) cyc(0, 0, 0);

    // Assertion after DELAY edges of continuous Req.
    repeat (3) cyc(0, 1, 0);
    // Clear masked while Req high, then release on Req drop.
    repeat (5) cyc(0, 1, 1);
    cyc(0, 0, 1);
    repeat (5) cyc(0, 0, 0);

    // Single-cycle Req glitch is filtered.
    cyc(0, 1, 0);
    repeat (3) cyc(0, 0, 0);

    // Release aborted by Req mid-walk.
    repeat (3) cyc(0, 1, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    repeat (3) cyc(0, 1, 0);
    cyc(0, 0, 1);
    repeat (5) cyc(0, 0, 0);

    // Quiet HOLD: watchdog release if built in, otherwise held indefinitely.
    cyc(1, 0, 0);
    repeat (100) cyc(0, 0, 0);
    repeat (3) cyc(0, 1, 0);
    cyc(0, 0, 1);
    repeat (5) cyc(0, 0, 0);

    // Random traffic.
    rq = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rq = ~rq;
      cyc(($urandom_range(0, 299) == 0), rq, ($urandom_range(0, 11) == 0));
    end

    // Timeout (if any) clears only with hard reset.
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    repeat (5) cyc(0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/flipflop_treset_seq.md
Name: flipflop_treset_seq

Overview:
- Parametrised successor to the single-channel delayed-reset latch.
- Converts a soft reset request (Req) into a latched, multi-channel reset level (TRESET). Assertion has a programmable delay. Release is acknowledged via Clear and then staggered across channels.
- Sits between CPU/APU reset-request logic and the per-unit reset inputs of downstream flipflop groups.

Parameters:
- CHANNELS, 4: number of TRESET outputs (1..16).
- DELAY, 2: edges from first Req sample to TRESET assertion (>=1).
- STAGGER, 1: edges between successive channel releases. 0 means all channels release together.
- CNT_W, 8: counter width. Must hold max(DELAY, STAGGER, HOLD_TIMEOUT).
- HOLD_TIMEOUT, 64: watchdog limit in cycles. Used only with the optional feature.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high hard reset.
- Req  in  1  soft reset request, level-sensitive.
- Clear  in  1  release acknowledge; effective only while Req is low.
- TRESET  out  CHANNELS  per-channel reset level; 1 means channel held in reset.
- Busy  out  1  high whenever state is not IDLE.
- Done  out  1  one-cycle pulse when the last channel is released.
- Timeout  out  1  sticky watchdog flag; tied 0 when the feature is compiled out.

Behaviour:
- States: IDLE, ARM, HOLD, RELEASE.
- Reset (RESET=1 at an edge), overriding all other inputs:
  - state <= HOLD, TRESET <= all ones, Busy=1, Done=0, Timeout=0, counters 0.
  - This applies mid-sequence from any state.
- IDLE:
  - TRESET all zeros.
  - Req=1 at edge e0 -> ARM.
- ARM:
  - TRESET stays zero.
  - If Req is sampled high at every edge e0..e0+DELAY, then state <= HOLD and TRESET <= all ones on edge e0+DELAY.
  - Req=0 at any edge in ARM -> IDLE; no output change (glitch filter).
- HOLD:
  - TRESET all ones.
  - Clear=1 && Req=0 at edge r0 -> RELEASE; TRESET[0] <= 0 on r0.
  - Clear=1 with Req=1 is ignored.
- RELEASE:
  - TRESET[k] <= 0 on edge r0 + k*STAGGER.
  - On edge r0 + (CHANNELS-1)*STAGGER: state <= IDLE, Busy <= 0, Done <= 1 for exactly the next cycle.
  - STAGGER=0: all bits clear on r0, IDLE on r0, Done the next cycle.
  - Req=1 during RELEASE -> HOLD with TRESET all ones on that edge; no DELAY applied; Done not pulsed.
  - Clear is don't-care during RELEASE.
- Released channels never re-assert except via a HOLD entry.
- CHANNELS=1 and STAGGER=0 reproduces legacy single-TRESET timing, DELAY=2.
- Counter arithmetic is unsigned and saturating. Elaboration error if any limit exceeds 2^CNT_W-1.

Optional Feature:
- Macro: FLIPFLOP_TRESET_WDOG_EN.
- With the macro:
  - In HOLD with Req=0, a counter runs.
  - If HOLD_TIMEOUT consecutive edges pass without Clear, the block enters RELEASE as if Clear had arrived, and Timeout <= 1.
  - Timeout is sticky until RESET.
  - The counter clears on Req=1 or on leaving HOLD.
- Without the macro: no watchdog; HOLD persists indefinitely; Timeout constant 0.

Decomposition:
- Package flipflop_treset_pkg holds:
  - state enum (IDLE, ARM, HOLD, RELEASE);
  - a function computing the minimum CNT_W from the parameters.
- Sub-module flipflop_treset_tick: a loadable, saturating up-counter with terminal-match output. It is reused for the ARM delay, the stagger spacing and the watchdog.

Test Plan (CHANNELS=4, DELAY=2, STAGGER=1 unless stated):
- Reset:
  - RESET high 1 cycle -> TRESET=4'b1111, Busy=1, Done=0.
  - Then Req=0, Clear=1 at r0 -> TRESET 1110, 1100, 1000, 0000 on r0..r0+3; Done=1 in the cycle after r0+3 only.
- Assert delay: from IDLE, Req held high from e0 -> TRESET=0 after e0 and e0+1, TRESET=1111 after e0+2.
- Glitch filter: Req high for 1 cycle only -> TRESET stays 0000; returns to IDLE, Busy low after 2 edges.
- Clear masking:
  - In HOLD, Clear=1 with Req=1 for 5 cycles -> TRESET stays 1111.
  - Drop Req -> release begins on that edge.
- Release abort: Req=1 at r0+1 (TRESET=1100) -> TRESET=1111 on that edge, state HOLD, no Done.
- Watchdog (FLIPFLOP_TRESET_WDOG_EN, HOLD_TIMEOUT=8): HOLD with Req=0, no Clear -> release starts on the 8th edge and Timeout=1 stays high until RESET.
- Without the macro, the same stimulus -> TRESET stays 1111 for 100 cycles and Timeout=0.
